// File: rtl/mux_scan_nx1.sv
// rtl/mux_scan_nx1.sv - registered N-channel selector with manual select and masked dwell scan
module mux_scan_nx1 #(
    parameter int N_CH  = 16,
    parameter int W     = 1,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*W-1:0]     in,
    input  logic                  en,
    input  logic                  mode,
    input  logic [$clog2(N_CH)-1:0] sel,
    input  logic [N_CH-1:0]       ch_mask,
    output logic [W-1:0]          out,
    output logic [$clog2(N_CH)-1:0] out_ch,
    output logic                  out_valid,
    output logic                  wrap
);

    localparam int SW = $clog2(N_CH);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);

    logic [SW-1:0] cur_ch;
    logic [DW-1:0] dwell_cnt;
    logic          mode_q;

    logic [SW-1:0] first_ch, next_ch, sel_idx;
    logic          first_found, next_found, sel_ok;
    logic [W-1:0]  cur_data, sel_data;

    // Descending loops let the lowest index / nearest successor win.
    // The successor search includes cur_ch itself last, so a lone set bit re-selects itself.
    always_comb begin
        first_ch    = '0;
        first_found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_ch    = SW'(i);
                first_found = 1'b1;
            end
        end
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = N_CH; i >= 1; i--) begin
            if (ch_mask[(32'(cur_ch) + i) % N_CH]) begin
                next_ch    = SW'((32'(cur_ch) + i) % N_CH);
                next_found = 1'b1;
            end
        end
    end

    assign sel_ok   = (32'(sel) < N_CH);
    assign sel_idx  = sel_ok ? sel : '0;
    assign sel_data = in[32'(sel_idx)*W +: W];
    assign cur_data = in[32'(cur_ch)*W +: W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            cur_ch    <= '0;
            dwell_cnt <= '0;
            mode_q    <= 1'b0;
        end else if (!en) begin
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else if (!mode) begin
            mode_q    <= 1'b0;
            dwell_cnt <= '0;
            wrap      <= 1'b0;
            if (sel_ok) begin
                out       <= sel_data;
                out_ch    <= sel;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (!mode_q) begin
            // Entry stays pending (mode_q low) until some mask bit is set.
            cur_ch    <= first_found ? first_ch : '0;
            dwell_cnt <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            mode_q    <= first_found;
        end else if (!next_found) begin
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else if (ch_mask[cur_ch]) begin
            out       <= cur_data;
            out_ch    <= cur_ch;
            out_valid <= 1'b1;
            if (dwell_cnt == DLAST) begin
                dwell_cnt <= '0;
                cur_ch    <= next_ch;
                wrap      <= (next_ch <= cur_ch);
            end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
                wrap      <= 1'b0;
            end
        end else begin
            out_valid <= 1'b0;
            cur_ch    <= next_ch;
            dwell_cnt <= '0;
            wrap      <= (next_ch <= cur_ch);
        end
    end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb/tb_mux_scan_nx1.sv - directed-vector bench for mux_scan_nx1
module tb_mux_scan_nx1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // a: 16x1 manual
    logic [15:0] in_a;
    logic [3:0]  sel_a, och_a;
    logic [0:0]  out_a;
    logic        val_a, wrap_a;

    // b: 4x8 DWELL=2, c: 4x8 DWELL=1, sharing stimulus
    logic [31:0] in_b;
    logic        en_b, mode_b;
    logic [3:0]  mask_b;
    logic [7:0]  out_b, out_c;
    logic [1:0]  och_b, och_c;
    logic        val_b, wrap_b, val_c, wrap_c;

    // d: 12x4 manual, out-of-range select
    logic [47:0] in_d;
    logic [3:0]  sel_d, och_d, out_d;
    logic        val_d, wrap_d;

    mux_scan_nx1 #(.N_CH(16), .W(1), .DWELL(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in(in_a), .en(1'b1), .mode(1'b0), .sel(sel_a),
        .ch_mask(16'hFFFF), .out(out_a), .out_ch(och_a), .out_valid(val_a), .wrap(wrap_a));

    mux_scan_nx1 #(.N_CH(4), .W(8), .DWELL(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in(in_b), .en(en_b), .mode(mode_b), .sel(2'd0),
        .ch_mask(mask_b), .out(out_b), .out_ch(och_b), .out_valid(val_b), .wrap(wrap_b));

    mux_scan_nx1 #(.N_CH(4), .W(8), .DWELL(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in(in_b), .en(en_b), .mode(mode_b), .sel(2'd0),
        .ch_mask(mask_b), .out(out_c), .out_ch(och_c), .out_valid(val_c), .wrap(wrap_c));

    mux_scan_nx1 #(.N_CH(12), .W(4), .DWELL(4)) dut_d (
        .clk(clk), .rst_n(rst_n), .in(in_d), .en(1'b1), .mode(1'b0), .sel(sel_d),
        .ch_mask(12'hFFF), .out(out_d), .out_ch(och_d), .out_valid(val_d), .wrap(wrap_d));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] pat;
    logic [7:0]  bval [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int          seq_ch [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int          seq_wr [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int          sp_ch  [6]  = '{1, 3, 1, 3, 1, 3};
    int          sp_wr  [6]  = '{0, 1, 0, 1, 0, 1};

    initial begin
        rst_n  = 1'b0;
        pat    = 16'hA5C3;
        in_a   = pat;
        sel_a  = 4'd0;
        in_b   = {8'h44, 8'h33, 8'h22, 8'h11};
        en_b   = 1'b1;
        mode_b = 1'b0;
        mask_b = 4'b1111;
        sel_d  = 4'd0;
        for (int k = 0; k < 12; k++) in_d[k*4 +: 4] = 4'(k);
        step();
        step();
        chk("rst_out_a", 32'(out_a), 0);
        chk("rst_val_a", 32'(val_a), 0);
        chk("rst_out_b", 32'(out_b), 0);
        chk("rst_och_b", 32'(och_b), 0);
        chk("rst_val_b", 32'(val_b), 0);
        chk("rst_wrap_b", 32'(wrap_b), 0);
        rst_n = 1'b1;

        for (int s = 0; s < 16; s++) begin
            sel_a = 4'(s);
            step();
            chk("man_out", 32'(out_a), 32'(pat[s]));
            chk("man_och", 32'(och_a), s);
            chk("man_val", 32'(val_a), 1);
            chk("man_wrap", 32'(wrap_a), 0);
        end

        mode_b = 1'b1;
        step();
        chk("scan_entry_val", 32'(val_b), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("scan_out", 32'(out_b), 32'(bval[seq_ch[i]]));
            chk("scan_och", 32'(och_b), seq_ch[i]);
            chk("scan_val", 32'(val_b), 1);
            chk("scan_wrap", 32'(wrap_b), seq_wr[i]);
        end

        mode_b = 1'b0;
        step();
        mask_b = 4'b1010;
        mode_b = 1'b1;
        step();
        chk("sparse_entry_val", 32'(val_c), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("sparse_och", 32'(och_c), sp_ch[i]);
            chk("sparse_out", 32'(out_c), 32'(bval[sp_ch[i]]));
            chk("sparse_val", 32'(val_c), 1);
            chk("sparse_wrap", 32'(wrap_c), sp_wr[i]);
        end

        mode_b = 1'b0;
        step();
        mask_b = 4'b1111;
        mode_b = 1'b1;
        step();
        step();
        chk("edit_pre_och", 32'(och_b), 0);
        chk("edit_pre_val", 32'(val_b), 1);
        mask_b = 4'b1110;
        step();
        chk("edit_bubble_val", 32'(val_b), 0);
        chk("edit_bubble_och", 32'(och_b), 0);
        step();
        chk("edit_next_och", 32'(och_b), 1);
        chk("edit_next_val", 32'(val_b), 1);
        step();
        chk("edit_next2_och", 32'(och_b), 1);
        mask_b = 4'b0000;
        step();
        chk("empty_val1", 32'(val_b), 0);
        step();
        chk("empty_val2", 32'(val_b), 0);
        chk("empty_och", 32'(och_b), 1);
        mask_b = 4'b1111;
        step();
        chk("refill_och", 32'(och_b), 2);
        chk("refill_out", 32'(out_b), 32'h33);
        chk("refill_val", 32'(val_b), 1);

        en_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("frz_val", 32'(val_b), 0);
            chk("frz_och", 32'(och_b), 2);
            chk("frz_out", 32'(out_b), 32'h33);
            chk("frz_wrap", 32'(wrap_b), 0);
        end
        en_b = 1'b1;
        step();
        chk("resume_och1", 32'(och_b), 2);
        chk("resume_val1", 32'(val_b), 1);
        step();
        chk("resume_och2", 32'(och_b), 3);
        chk("resume_out2", 32'(out_b), 32'h44);

        rst_n = 1'b0;
        step();
        chk("mid_rst_out", 32'(out_b), 0);
        chk("mid_rst_och", 32'(och_b), 0);
        chk("mid_rst_val", 32'(val_b), 0);
        chk("mid_rst_wrap", 32'(wrap_b), 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_entry_val", 32'(val_b), 0);
        step();
        chk("post_rst_och", 32'(och_b), 0);
        chk("post_rst_val", 32'(val_b), 1);

        sel_d = 4'd5;
        step();
        chk("d_out5", 32'(out_d), 5);
        chk("d_val5", 32'(val_d), 1);
        sel_d = 4'd13;
        step();
        chk("d_bad_val", 32'(val_d), 0);
        chk("d_bad_out", 32'(out_d), 5);
        chk("d_bad_och", 32'(och_d), 5);
        sel_d = 4'd11;
        step();
        chk("d_out11", 32'(out_d), 11);
        chk("d_och11", 32'(och_d), 11);
        sel_d = 4'd12;
        step();
        chk("d_edge_val", 32'(val_d), 0);
        chk("d_edge_out", 32'(out_d), 11);
        chk("d_wrap", 32'(wrap_d), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_nx1.md
# mux_scan_nx1

Parametrised, registered N-channel selector, successor to the fixed 16:1 single-bit multiplexer. It routes one W-bit channel out of N_CH channels either under direct select control (manual mode) or by autonomously cycling through an enable mask with a programmable dwell time (scan mode). It serves as the time-division front end for downstream serialisers and monitors that need one channel at a time, tagged with its index.

## Interface
- N_CH, 16, number of input channels (≥2)
- W, 1, bits per channel
- DWELL, 4, clock cycles spent on each channel in scan mode (≥1)
- SW (localparam), $clog2(N_CH), select and channel-index width
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in  in  N_CH*W  packed channels; channel k = in[k*W +: W]
- en  in  1  block enable; 0 freezes all state
- mode  in  1  0 = manual, 1 = scan
- sel  in  SW  channel index in manual mode
- ch_mask  in  N_CH  scan enable per channel (1 = visited)
- out  out  W  selected channel data, registered
- out_ch  out  SW  index of the channel driving out
- out_valid  out  1  out/out_ch carry a live sample this cycle
- wrap  out  1  one-cycle pulse when scan index wraps to a lower index

## Operation
- Internal state: cur_ch (SW), dwell_cnt (width clog2(DWELL), min 1), mode_q (registered mode).
- Reset (rst_n=0 at clk edge): out=0, out_ch=0, out_valid=0, wrap=0, cur_ch=0, dwell_cnt=0, mode_q=0. Reset overrides en.
- en=0: cur_ch, dwell_cnt, mode_q, out, out_ch hold; out_valid=0, wrap=0.
- Manual (en=1, mode=0): if sel<N_CH then out<=channel sel, out_ch<=sel, out_valid<=1; else out/out_ch hold, out_valid<=0. ch_mask ignored. wrap=0. dwell_cnt<=0.
- Scan entry (en=1, mode=1, mode_q=0): cur_ch<=lowest index with ch_mask=1, dwell_cnt<=0, out_valid<=0 this cycle. No set mask bit: cur_ch<=0, remain in entry condition next cycle (mode_q stays 0).
- Scan steady (en=1, mode=1, mode_q=1):
  - ch_mask[cur_ch]=1: out<=channel cur_ch, out_ch<=cur_ch, out_valid<=1; dwell_cnt increments; at dwell_cnt==DWELL-1, dwell_cnt<=0 and cur_ch<=next set mask bit strictly after cur_ch, wrapping modulo N_CH.
  - ch_mask[cur_ch]=0 (mask changed mid-dwell): out_valid<=0, immediate advance to next set bit, dwell_cnt<=0.
  - ch_mask all zero: out_valid<=0, cur_ch and dwell_cnt hold.
  - wrap<=1 on any advance whose new index ≤ old cur_ch (includes single-bit mask re-selecting itself); otherwise 0.
- mode_q<=mode when en=1 (subject to entry rule above). Scan→manual→scan always restarts at lowest set bit.
- Data is live: out samples in during the update cycle, not at channel entry.

## Timing
- Manual latency: 1 cycle from sel/in to out/out_ch/out_valid.
- Scan: first valid sample 2 cycles after mode rises (entry cycle + first dwell cycle). Each channel valid for exactly DWELL consecutive cycles with a constant mask; DWELL=1 advances every cycle.
- wrap asserts in the same cycle the registered cur_ch update occurs; visible on out_ch one cycle later.
- Next-set-bit search is combinational over N_CH, single cycle; no bubbles between channels in steady scan.

## Test plan
- Manual, N_CH=16, W=1: in=16'hA5C3, sel sweeps 0..15 -> out next cycle equals in[sel], out_ch=sel, out_valid=1, wrap=0.
- Scan, N_CH=4, W=8, DWELL=2, ch_mask=4'b1111, in={8'h44,8'h33,8'h22,8'h11} -> after 1-cycle entry, out sequence 11,11,22,22,33,33,44,44,11…; wrap pulses once per 8 cycles as 3→0.
- Sparse mask: ch_mask=4'b1010, DWELL=1 -> out_ch alternates 1,3,1,3; wrap on every 3→1 transition; channels 0,2 never appear.
- Mask edits: clear ch_mask[cur_ch] mid-dwell -> one cycle out_valid=0 then next set channel; clear all bits -> out_valid=0 and cur_ch holds until a bit is set.
- en low for 5 cycles mid-dwell -> out/out_ch frozen, out_valid=0; resume continues same channel with remaining dwell.
- rst_n low for one edge mid-scan -> all outputs 0 next cycle; sel=N_CH-invalid (e.g. N_CH=12, sel=13) in manual -> out_valid=0, out holds.
